// File: rtl/clkdiv_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master side drives enables, divider writes and busy; the slave side returns ticks and counts.
interface clkdiv_multi_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned BCNT_W = 32,
  parameter int unsigned SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]    en;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic              busy;
  logic              bcnt_clr;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    clk_div;
  logic [BCNT_W-1:0] busycount;

  modport master (
    output en, div_we, div_sel, div_val, busy, bcnt_clr,
    input  tick, clk_div, busycount
  );

  modport slave (
    input  en, div_we, div_sel, div_val, busy, bcnt_clr,
    output tick, clk_div, busycount
  );
endinterface

// File: rtl/clkdiv_multi.sv
// NCH independent programmable clock-enable dividers, each with a registered tick and square wave,
// plus a saturating busy counter of channel-0 rising edges kept entirely in the clk domain.
module clkdiv_multi #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 4,
  parameter int unsigned BCNT_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  clkdiv_multi_if.slave bus
);

  logic [CNT_W-1:0]  cnt   [NCH];
  logic [CNT_W-1:0]  div_r [NCH];
  logic [NCH-1:0]    tick_q;
  logic [NCH-1:0]    clk_div_q;
  logic [BCNT_W-1:0] bcnt_q;

  logic [NCH-1:0]    we_hit_c;
  logic [NCH-1:0]    tc_c;
  logic              inc_c;

  // Write decode and terminal-count detect; an out-of-range select matches no channel.
  always_comb begin
    we_hit_c = '0;
    tc_c     = '0;
    for (int i = 0; i < NCH; i++) begin
      we_hit_c[i] = bus.div_we && (32'(bus.div_sel) == 32'(i));
      tc_c[i]     = bus.en[i] && (cnt[i] == (div_r[i] - CNT_W'(1)));
    end
    // Count on the edge where channel 0 is about to rise; a same-cycle write suppresses it.
    inc_c = bus.busy && tc_c[0] && !we_hit_c[0] && !clk_div_q[0];
  end

  // Per-channel divider state; a write takes priority over the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        div_r[i] <= CNT_W'(DEF_DIV);
      end
      tick_q    <= '0;
      clk_div_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (we_hit_c[i]) begin
          div_r[i]  <= (bus.div_val == '0) ? CNT_W'(1) : bus.div_val;
          cnt[i]    <= '0;
          tick_q[i] <= 1'b0;
        end else if (tc_c[i]) begin
          cnt[i]       <= '0;
          tick_q[i]    <= 1'b1;
          clk_div_q[i] <= ~clk_div_q[i];
        end else if (bus.en[i]) begin
          cnt[i]    <= cnt[i] + CNT_W'(1);
          tick_q[i] <= 1'b0;
        end else begin
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  // Busy counter: clear wins over increment, increment saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
    end else if (bus.bcnt_clr) begin
      bcnt_q <= '0;
    end else if (inc_c && (bcnt_q != '1)) begin
      bcnt_q <= bcnt_q + BCNT_W'(1);
    end
  end

  assign bus.tick      = tick_q;
  assign bus.clk_div   = clk_div_q;
  assign bus.busycount = bcnt_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: a 2-channel default instance and a 3-channel instance
// with a 3-bit busy counter for saturation and out-of-range select cases.
module tb_clkdiv_multi;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  clkdiv_multi_if #(.NCH(2), .CNT_W(16), .BCNT_W(32)) bus_a ();
  clkdiv_multi_if #(.NCH(3), .CNT_W(16), .BCNT_W(3))  bus_b ();

  clkdiv_multi #(.NCH(2), .CNT_W(16), .DEF_DIV(4), .BCNT_W(32)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  clkdiv_multi #(.NCH(3), .CNT_W(16), .DEF_DIV(4), .BCNT_W(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.en = '0; bus_a.div_we = 1'b0; bus_a.div_sel = '0; bus_a.div_val = '0;
    bus_a.busy = 1'b0; bus_a.bcnt_clr = 1'b0;
    bus_b.en = '0; bus_b.div_we = 1'b0; bus_b.div_sel = '0; bus_b.div_val = '0;
    bus_b.busy = 1'b0; bus_b.bcnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_tick_a", 64'(bus_a.tick), 64'd0);
    check("rst_div_a",  64'(bus_a.clk_div), 64'd0);
    check("rst_bcnt_a", 64'(bus_a.busycount), 64'd0);
    check("rst_tick_b", 64'(bus_b.tick), 64'd0);
    check("rst_div_b",  64'(bus_b.clk_div), 64'd0);
    check("rst_bcnt_b", 64'(bus_b.busycount), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    step(2);

    // T1: default half-period 4 on channel 0, channel 1 idle
    do_reset();
    bus_a.en = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("t1_tick0", 64'(bus_a.tick[0]), 64'(k % 4 == 0));
      check("t1_div0",  64'(bus_a.clk_div[0]), 64'((k / 4) % 2));
      check("t1_ch1",   64'({bus_a.tick[1], bus_a.clk_div[1]}), 64'd0);
    end

    // T2: channel 1 set to 3 while both run; channel 0 keeps half-period 4
    do_reset();
    bus_a.en = 2'b11; bus_a.div_we = 1'b1; bus_a.div_sel = 1'b1; bus_a.div_val = 16'd3;
    step(1);
    bus_a.div_we = 1'b0;
    check("t2_wr_ch1", 64'({bus_a.tick[1], bus_a.clk_div[1]}), 64'd0);
    for (int j = 1; j <= 12; j++) begin
      step(1);
      check("t2_tick0", 64'(bus_a.tick[0]), 64'(j % 4 == 3));
      check("t2_div0",  64'(bus_a.clk_div[0]), 64'(((j + 1) / 4) % 2));
      check("t2_tick1", 64'(bus_a.tick[1]), 64'(j % 3 == 0));
      check("t2_div1",  64'(bus_a.clk_div[1]), 64'((j / 3) % 2));
    end

    // T3: half-period 0 behaves as 1
    do_reset();
    bus_a.en = 2'b01; bus_a.div_we = 1'b1; bus_a.div_sel = 1'b0; bus_a.div_val = 16'd0;
    step(1);
    bus_a.div_we = 1'b0;
    check("t3_wr", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'd0);
    for (int j = 1; j <= 6; j++) begin
      step(1);
      check("t3_tick0", 64'(bus_a.tick[0]), 64'd1);
      check("t3_div0",  64'(bus_a.clk_div[0]), 64'(j % 2));
    end

    // T4: enable gap freezes the count; then a write on the terminal cycle
    do_reset();
    bus_a.en = 2'b01;
    step(2);
    bus_a.en = 2'b00;
    for (int j = 0; j < 5; j++) begin
      step(1);
      check("t4_frz", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'd0);
    end
    bus_a.en = 2'b01;
    step(1);
    check("t4_res1", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b00);
    step(1);
    check("t4_res2", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b11);
    step(3);
    check("t4_pre_tc", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b01);
    bus_a.div_we = 1'b1; bus_a.div_sel = 1'b0; bus_a.div_val = 16'd4;
    step(1);
    bus_a.div_we = 1'b0;
    check("t4_wr_tc", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b01);
    step(3);
    check("t4_after3", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b01);
    step(1);
    check("t4_after4", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b10);

    // T5: busy counting, clear priority, busy gating, saturation on a 3-bit counter
    do_reset();
    bus_a.en = 2'b01; bus_a.busy = 1'b1;
    step(32);
    check("t5_bcnt32", 64'(bus_a.busycount), 64'd4);
    step(3);
    check("t5_bcnt35", 64'(bus_a.busycount), 64'd4);
    bus_a.bcnt_clr = 1'b1;
    step(1);
    bus_a.bcnt_clr = 1'b0;
    check("t5_clr", 64'(bus_a.busycount), 64'd0);
    bus_a.busy = 1'b0;
    step(8);
    check("t5_nobusy", 64'(bus_a.busycount), 64'd0);

    do_reset();
    bus_b.en = 3'b001; bus_b.busy = 1'b1;
    step(44);
    check("t5_b6", 64'(bus_b.busycount), 64'd6);
    step(32);
    check("t5_bsat", 64'(bus_b.busycount), 64'd7);

    // T6: asynchronous reset mid-count restores the default half-period
    do_reset();
    bus_a.en = 2'b01; bus_a.busy = 1'b1;
    bus_a.div_we = 1'b1; bus_a.div_sel = 1'b0; bus_a.div_val = 16'd2;
    step(1);
    bus_a.div_we = 1'b0;
    step(10);
    check("t6_bcnt", 64'(bus_a.busycount), 64'd3);
    check("t6_pre", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_tick", 64'(bus_a.tick), 64'd0);
    check("t6_async_div",  64'(bus_a.clk_div), 64'd0);
    check("t6_async_bcnt", 64'(bus_a.busycount), 64'd0);
    bus_a.busy = 1'b0;
    rst_n = 1'b1;
    step(3);
    check("t6_rel3", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b00);
    step(1);
    check("t6_rel4", 64'({bus_a.tick[0], bus_a.clk_div[0]}), 64'b11);

    // Out-of-range select on the 3-channel instance touches no channel
    do_reset();
    bus_b.en = 3'b111; bus_b.div_we = 1'b1; bus_b.div_sel = 2'd3; bus_b.div_val = 16'd1;
    step(1);
    bus_b.div_we = 1'b0;
    step(2);
    check("t6_badsel3", 64'({bus_b.tick, bus_b.clk_div}), 64'd0);
    step(1);
    check("t6_badsel4", 64'({bus_b.tick, bus_b.clk_div}), 64'h3f);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
